// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter (and the future
// receiver that will reuse the bit timer).
//   - uart_state_e : frame state encoding, also exported on the debug port
//   - parity mode constants for the PARITY_ODD parameter
//   - default baud divisors for 115200 baud at common system clocks
//   - frame_parity(): parity of a zero-extended data word
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    GUARD  = 3'd5
  } uart_state_e;

  localparam bit PARITY_MODE_EVEN = 1'b0;
  localparam bit PARITY_MODE_ODD  = 1'b1;

  // CLKS_PER_BIT for 115200 baud.
  localparam int DIV_115200_AT_100MHZ = 868;
  localparam int DIV_115200_AT_12M5HZ = 109;

  localparam int MAX_DATA_W = 9;

  // Zero padding does not change the XOR, so narrower words can be
  // passed zero-extended to MAX_DATA_W.
  function automatic logic frame_parity(input logic [MAX_DATA_W-1:0] d,
                                        input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter with terminal-count output.
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset, clears the count
//   load     : load load_val this cycle (takes priority over counting)
//   load_val : value loaded; a period of N cycles is loaded as N-1
//   tick     : high while the count is zero (last cycle of the period)
module uart_bit_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tick
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign tick = (count_q == '0);

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with a one-entry holding buffer.
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset; aborts any frame
//   in_data   : word to send, captured on in_valid && in_ready
//   in_valid  : producer has data
//   in_ready  : holding buffer empty
//   tx_out    : serial line, idle high, registered
//   busy      : frame on the line (start bit through last guard cycle)
//   tx_done   : one-cycle pulse on the last guard cycle of each frame
//   dbg_state : current FSM state (uart_state_e encoding)
//
// Handshake: a transfer happens on every rising edge where in_valid and
// in_ready are both high; in_ready is simply !hold_valid, so it never depends
// on in_valid, and in_data is ignored whenever in_ready is low.
//
// The line outputs are registered from the FSM state, so tx_out/busy/tx_done
// trail the state register by one cycle; every state lasts exactly its
// nominal duration, so the line timing is unchanged, just shifted.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 50,
  parameter int DATA_W       = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  parameter int GUARD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              tx_done,
  output logic [2:0]        dbg_state
);

  if (DATA_W < 5 || DATA_W > MAX_DATA_W || !(STOP_BITS == 1 || STOP_BITS == 2) ||
      CLKS_PER_BIT < 2 || GUARD_CYCLES < 1) begin : g_bad_params
    $error("uart_tx_param: illegal parameter combination");
  end

  // The timer also paces the guard interval, so it is sized for whichever
  // of the stop period and the guard interval is longer.
  localparam int STOP_CYC = CLKS_PER_BIT * STOP_BITS;
  localparam int TMAX     = (STOP_CYC > GUARD_CYCLES) ? STOP_CYC : GUARD_CYCLES;
  localparam int TW       = $clog2(TMAX);
  localparam int IW       = $clog2(DATA_W);

  localparam logic [TW-1:0] BIT_LD   = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] STOP_LD  = TW'(STOP_CYC - 1);
  localparam logic [TW-1:0] GUARD_LD = TW'(GUARD_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);
  localparam logic          ODD_SEL  = (PARITY_ODD != 0);

  uart_state_e       state_q, state_d;
  logic [DATA_W-1:0] hold_q;
  logic              hold_valid_q;
  logic [DATA_W-1:0] shift_q;
  logic              par_q;
  logic [IW-1:0]     idx_q;
  logic              tx_q, busy_q, done_q;

  logic              accept;
  logic              load_frame;
  logic              line_d;
  logic              tmr_load;
  logic [TW-1:0]     tmr_val;
  logic              tmr_tick;

  uart_bit_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tick     (tmr_tick)
  );

  assign accept = in_valid && !hold_valid_q;

  // Next state, timer reload and the line level for the current state.
  // The timer is reloaded on every state exit, so each state lasts exactly
  // (loaded value + 1) cycles.
  always_comb begin
    state_d    = state_q;
    tmr_load   = 1'b0;
    tmr_val    = BIT_LD;
    load_frame = 1'b0;
    line_d     = 1'b1;
    case (state_q)
      IDLE: begin
        if (hold_valid_q) begin
          load_frame = 1'b1;
          tmr_load   = 1'b1;
          state_d    = START;
        end
      end
      START: begin
        line_d = 1'b0;
        if (tmr_tick) begin
          tmr_load = 1'b1;
          state_d  = DATA;
        end
      end
      DATA: begin
        line_d = shift_q[0];
        if (tmr_tick) begin
          tmr_load = 1'b1;
          if (idx_q == LAST_IDX) begin
            if (PARITY_EN != 0) begin
              state_d = PARITY;
            end else begin
              state_d = STOP;
              tmr_val = STOP_LD;
            end
          end
        end
      end
      PARITY: begin
        line_d = par_q;
        if (tmr_tick) begin
          tmr_load = 1'b1;
          tmr_val  = STOP_LD;
          state_d  = STOP;
        end
      end
      STOP: begin
        if (tmr_tick) begin
          tmr_load = 1'b1;
          tmr_val  = GUARD_LD;
          state_d  = GUARD;
        end
      end
      GUARD: begin
        if (tmr_tick) begin
          if (hold_valid_q) begin
            // Back-to-back: next start bit follows the guard directly.
            load_frame = 1'b1;
            tmr_load   = 1'b1;
            state_d    = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      idx_q        <= '0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q <= state_d;

      // accept and load_frame are exclusive: accept needs an empty buffer,
      // load_frame a full one.
      if (accept) begin
        hold_q       <= in_data;
        hold_valid_q <= 1'b1;
      end else if (load_frame) begin
        hold_valid_q <= 1'b0;
      end

      if (load_frame) begin
        shift_q <= hold_q;
        par_q   <= frame_parity(MAX_DATA_W'(hold_q), ODD_SEL);
      end else if (state_q == DATA && tmr_tick) begin
        shift_q <= shift_q >> 1;
      end

      if (state_q == DATA && tmr_tick) begin
        idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      end

      tx_q   <= line_d;
      busy_q <= (state_q != IDLE);
      done_q <= (state_q == GUARD) && tmr_tick;
    end
  end

  assign in_ready  = !hold_valid_q;
  assign tx_out    = tx_q;
  assign busy      = busy_q;
  assign tx_done   = done_q;
  assign dbg_state = state_q;

endmodule
